// File: rtl/axis_dot_mac.sv
// Streaming fixed-point dot-product MAC: LANES products per beat, summed and accumulated per frame.
// Define MAC_SAT_EN to clamp out-of-range results and flag them on m_ovf; otherwise results wrap.
module axis_dot_mac #(
   parameter int LANES    = 4,
   parameter int INT_A    = 6,
   parameter int FRAC_A   = 8,
   parameter int INT_B    = 6,
   parameter int FRAC_B   = 8,
   parameter int GUARD    = 8,
   parameter int OUT_INT  = 12,
   parameter int OUT_FRAC = 16
) (
   input  logic                                 clock,
   input  logic                                 rstn,
   input  logic [LANES*(INT_A+FRAC_A)-1:0]      s_a,
   input  logic [LANES*(INT_B+FRAC_B)-1:0]      s_b,
   input  logic                                 s_valid,
   input  logic                                 s_last,
   output logic                                 s_ready,
   output logic [OUT_INT+OUT_FRAC-1:0]          m_data,
   output logic                                 m_valid,
   output logic                                 m_last,
   input  logic                                 m_ready,
   output logic [15:0]                          m_count,
   output logic                                 m_ovf
);
   localparam int WA   = INT_A + FRAC_A;
   localparam int WB   = INT_B + FRAC_B;
   localparam int PI   = INT_A + INT_B;
   localparam int PF   = FRAC_A + FRAC_B;
   localparam int WP   = PI + PF;
   localparam int LG   = $clog2(LANES);
   localparam int WACC = PI + PF + LG + GUARD;
   localparam int WO   = OUT_INT + OUT_FRAC;
   localparam int WC   = (OUT_FRAC < PF) ? WACC + 1 : WACC + OUT_FRAC - PF;

   typedef enum logic {IDLE, ACC} state_t;
   state_t state_reg, state_next;

   logic                   stall, accept;
   logic signed [WP-1:0]   prod_next [LANES];
   logic signed [WP-1:0]   prod_reg  [LANES];
   logic                   p1_valid_reg, p1_last_reg;
   logic signed [WACC-1:0] acc_reg, lane_sum, total;
   logic [15:0]            cnt_reg, cnt_inc;
   logic signed [WC-1:0]   conv;
   logic [WO-1:0]          fit_data, m_data_reg;
   logic [15:0]            m_count_reg;
   logic                   m_valid_reg;

   // A result that has not been taken freezes the whole datapath.
   assign stall   = m_valid_reg && !m_ready;
   assign s_ready = !rstn && !stall;
   assign accept  = s_valid && s_ready;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign prod_next[gi] = $signed(s_a[gi*WA +: WA]) * $signed(s_b[gi*WB +: WB]);
      end
   endgenerate

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + WACC'(prod_reg[i]);
      end
   end

   assign total   = acc_reg + lane_sum;
   assign cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

   generate
      if (OUT_FRAC < PF) begin : g_round
         localparam int SH = PF - OUT_FRAC;
         localparam int WE = WACC + 1;
         localparam logic signed [WACC:0] HALF = WE'(1) <<< (SH - 1);
         logic signed [WACC:0] ext;
         // One extra bit so adding the half-LSB can never overflow.
         assign ext  = {total[WACC-1], total};
         assign conv = (ext + HALF) >>> SH;
      end else begin : g_shift
         localparam int SH = OUT_FRAC - PF;
         assign conv = WC'(total) <<< SH;
      end
   endgenerate

`ifdef MAC_SAT_EN
   logic fit_ovf;
`endif

   generate
      if (WC > WO) begin : g_fit
`ifdef MAC_SAT_EN
         logic fits;
         assign fits     = (&conv[WC-1:WO-1]) || !(|conv[WC-1:WO-1]);
         assign fit_data = fits ? conv[WO-1:0] : {conv[WC-1], {(WO-1){!conv[WC-1]}}};
         assign fit_ovf  = !fits;
`else
         logic unused_hi;
         assign unused_hi = ^conv[WC-1:WO];
         assign fit_data  = conv[WO-1:0];
`endif
      end else begin : g_ext
         assign fit_data = WO'(conv);
`ifdef MAC_SAT_EN
         assign fit_ovf  = 1'b0;
`endif
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (rstn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (accept) begin
         state_next = s_last ? IDLE : ACC;
      end
   end

   always_ff @(posedge clock) begin
      if (rstn) begin
         p1_valid_reg <= 1'b0;
         p1_last_reg  <= 1'b0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         m_valid_reg  <= 1'b0;
         m_data_reg   <= '0;
         m_count_reg  <= '0;
         for (int i = 0; i < LANES; i++) begin
            prod_reg[i] <= '0;
         end
      end else if (!stall) begin
         p1_valid_reg <= accept;
         p1_last_reg  <= accept && s_last;
         if (accept) begin
            for (int i = 0; i < LANES; i++) begin
               prod_reg[i] <= prod_next[i];
            end
         end
         m_valid_reg <= 1'b0;
         // Closing beat: publish the result and restart the frame on the same edge.
         if (p1_valid_reg) begin
            if (p1_last_reg) begin
               acc_reg     <= '0;
               cnt_reg     <= '0;
               m_valid_reg <= 1'b1;
               m_data_reg  <= fit_data;
               m_count_reg <= cnt_inc;
            end else begin
               acc_reg <= total;
               cnt_reg <= cnt_inc;
            end
         end
      end
   end

`ifdef MAC_SAT_EN
   logic m_ovf_reg;
   always_ff @(posedge clock) begin
      if (rstn) begin
         m_ovf_reg <= 1'b0;
      end else if (!stall && p1_valid_reg && p1_last_reg) begin
         m_ovf_reg <= fit_ovf;
      end
   end
   assign m_ovf = m_ovf_reg;
`else
   assign m_ovf = 1'b0;
`endif

   assign m_data  = m_data_reg;
   assign m_valid = m_valid_reg;
   assign m_last  = m_valid_reg;
   assign m_count = m_count_reg;
endmodule

// File: tb/tb_axis_dot_mac.sv
// Self-checking bench for axis_dot_mac: default instance plus a one-lane, 8-fraction-bit instance for rounding.
// Reference model works on exact integer dot products in units of 2^-16.
module tb_axis_dot_mac;
   localparam int LANES = 4;
   localparam int WA    = 14;
   localparam int WO    = 28;
   localparam int R_WO  = 20;
   localparam longint MAXV = (64'sd1 <<< (WO-1)) - 64'sd1;
   localparam longint MINV = -(64'sd1 <<< (WO-1));

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                  rstn;
   logic [LANES*WA-1:0]   s_a, s_b;
   logic                  s_valid, s_last, s_ready;
   logic [WO-1:0]         m_data;
   logic                  m_valid, m_last, m_ready, m_ovf;
   logic [15:0]           m_count;

   logic [WA-1:0]         r_s_a, r_s_b;
   logic                  r_s_valid, r_s_last, r_s_ready;
   logic [R_WO-1:0]       r_m_data;
   logic                  r_m_valid, r_m_last, r_m_ready, r_m_ovf;
   logic [15:0]           r_m_count;

   axis_dot_mac u_dut (
      .clock(clock), .rstn(rstn), .s_a(s_a), .s_b(s_b), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .m_count(m_count), .m_ovf(m_ovf)
   );

   axis_dot_mac #(.LANES(1), .OUT_FRAC(8)) u_rnd (
      .clock(clock), .rstn(rstn), .s_a(r_s_a), .s_b(r_s_b), .s_valid(r_s_valid), .s_last(r_s_last),
      .s_ready(r_s_ready), .m_data(r_m_data), .m_valid(r_m_valid), .m_last(r_m_last), .m_ready(r_m_ready),
      .m_count(r_m_count), .m_ovf(r_m_ovf)
   );

   typedef struct packed {
      logic [WO-1:0] data;
      logic [15:0]   cnt;
      logic          ovf;
   } res_t;

   int     checks = 0;
   int     failures = 0;
   int     timeouts = 0;
   res_t   exp_q[$];
   res_t   obs_q[$];
   longint macc = 0;
   int     mcnt = 0;

   function automatic res_t model_fit(input longint total, input int cnt);
      res_t   r;
      longint lim;
      r.cnt  = 16'(cnt);
      r.ovf  = 1'b0;
      r.data = total[WO-1:0];
`ifdef MAC_SAT_EN
      if (total > MAXV) begin
         lim = MAXV;
         r.data = lim[WO-1:0];
         r.ovf = 1'b1;
      end else if (total < MINV) begin
         lim = MINV;
         r.data = lim[WO-1:0];
         r.ovf = 1'b1;
      end
`endif
      return r;
   endfunction

   function automatic logic [LANES*WA-1:0] pack(input int v0, input int v1, input int v2, input int v3);
      return {WA'(v3), WA'(v2), WA'(v1), WA'(v0)};
   endfunction

   function automatic logic [LANES*WA-1:0] rand_vec();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[LANES*WA-1:0];
   endfunction

   // Model: exact frame sums of accepted beats; observed results captured at each output handshake.
   always @(negedge clock) begin
      if (rstn) begin
         macc = 0;
         mcnt = 0;
         exp_q.delete();
         obs_q.delete();
      end else begin
         if (m_valid && m_ready) obs_q.push_back({m_data, m_count, m_ovf});
         if (s_valid && s_ready) begin
            for (int i = 0; i < LANES; i++)
               macc += longint'($signed(s_a[i*WA +: WA])) * longint'($signed(s_b[i*WA +: WA]));
            if (mcnt < 65535) mcnt++;
            if (s_last) begin
               exp_q.push_back(model_fit(macc, mcnt));
               macc = 0;
               mcnt = 0;
            end
         end
      end
   end

   task automatic send_beat(input logic [LANES*WA-1:0] a, input logic [LANES*WA-1:0] b,
                            input logic last, input bit rnd_ready);
      bit acc;
      acc = 1'b0;
      s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         if (rnd_ready) m_ready = ($urandom_range(0, 9) < 7);
         @(negedge clock);
         acc = s_ready;
         @(posedge clock); #1;
         if (acc) break;
      end
      if (!acc) timeouts++;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      m_ready = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(posedge clock); #1;
         if (obs_q.size() == exp_q.size() && !m_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) timeouts++;
   endtask

   task automatic test_reset();
      rstn = 1'b1; s_valid = 1'b1; s_last = 1'b1; s_a = rand_vec(); s_b = rand_vec();
      repeat (3) @(posedge clock);
      #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
      checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b required 0", m_last); end
      checks++; if (m_ovf !== 1'b0) begin failures++; $display("FAIL reset_m_ovf: got %b required 0", m_ovf); end
      checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data: got %h required 0", m_data); end
      checks++; if (m_count !== 16'd0) begin failures++; $display("FAIL reset_m_count: got %0d required 0", m_count); end
      checks++; if (r_m_valid !== 1'b0) begin failures++; $display("FAIL reset_r_m_valid: got %b required 0", r_m_valid); end
      s_valid = 1'b0;
      rstn = 1'b0;
      @(posedge clock); #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL release_s_ready: got %b required 1", s_ready); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL release_m_valid: got %b required 0", m_valid); end
      $display("test_reset done");
   endtask

   task automatic test_single_beat();
      res_t e, o;
      m_ready = 1'b1;
      s_a = pack(256, 512, -256, 128); s_b = pack(256, 256, 256, 512); s_last = 1'b1; s_valid = 1'b1;
      @(negedge clock);
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL single_s_ready: got %b required 1", s_ready); end
      @(posedge clock); #1;
      s_valid = 1'b0;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b required 0", m_valid); end
      @(posedge clock); #1;
      checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_latency: m_valid got %b required 1", m_valid); end
      checks++; if (m_last !== 1'b1) begin failures++; $display("FAIL single_m_last: got %b required 1", m_last); end
      checks++; if (m_data !== 28'h0030000) begin failures++; $display("FAIL single_data: got %h required 0030000", m_data); end
      checks++; if (m_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d required 1", m_count); end
      drain();
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_nres: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL single_model: got data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b", o.data, o.cnt, o.ovf, e.data, e.cnt, e.ovf); end
      end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL single_timeout: got %0d timeouts required 0", timeouts); end
      timeouts = 0;
      $display("test_single_beat done");
   endtask

   task automatic test_back_to_back();
      res_t e, o;
      bit   dropped;
      int   run, maxrun;
      dropped = 1'b0; run = 0; maxrun = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 6) begin
            s_a = pack(256, 256, 256, 256); s_b = pack(256, 256, 256, 256); s_last = (i % 3 == 2);
         end else begin
            s_a = rand_vec(); s_b = rand_vec(); s_last = 1'b1;
         end
         s_valid = 1'b1;
         @(negedge clock);
         if (s_ready !== 1'b1) dropped = 1'b1;
         run = m_valid ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         @(posedge clock); #1;
      end
      s_valid = 1'b0;
      repeat (3) begin
         @(negedge clock);
         run = m_valid ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         @(posedge clock); #1;
      end
      checks++; if (dropped) begin failures++; $display("FAIL b2b_s_ready: got dropped=1 required 0"); end
      checks++; if (maxrun != 4) begin failures++; $display("FAIL b2b_valid_run: got %0d required 4", maxrun); end
      drain();
      checks++;
      if (obs_q.size() < 2) begin failures++; $display("FAIL b2b_first: got %0d results required >=2", obs_q.size()); end
      else begin
         checks++; if (obs_q[0].data !== 28'h00C0000 || obs_q[0].cnt !== 16'd3) begin failures++; $display("FAIL b2b_frame0: got data=%h cnt=%0d required 00c0000 3", obs_q[0].data, obs_q[0].cnt); end
         checks++; if (obs_q[1].data !== 28'h00C0000 || obs_q[1].cnt !== 16'd3) begin failures++; $display("FAIL b2b_frame1: got data=%h cnt=%0d required 00c0000 3", obs_q[1].data, obs_q[1].cnt); end
      end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_nres: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL b2b_model: got data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b", o.data, o.cnt, o.ovf, e.data, e.cnt, e.ovf); end
      end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL b2b_timeout: got %0d timeouts required 0", timeouts); end
      timeouts = 0;
      $display("test_back_to_back done");
   endtask

   task automatic test_backpressure();
      res_t          e, o;
      logic [WO-1:0] d0;
      logic [15:0]   c0;
      bit            held_ok, acc;
      m_ready = 1'b0;
      send_beat(rand_vec(), rand_vec(), 1'b1, 1'b0);
      s_a = rand_vec(); s_b = rand_vec(); s_last = 1'b0; s_valid = 1'b1;
      @(posedge clock); #1;
      s_a = rand_vec(); s_b = rand_vec(); s_last = 1'b1;
      d0 = m_data; c0 = m_count; held_ok = 1'b1;
      repeat (5) begin
         @(negedge clock);
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== d0 || m_count !== c0) held_ok = 1'b0;
         @(posedge clock); #1;
      end
      checks++; if (!held_ok) begin failures++; $display("FAIL stall_hold: got s_ready=%b m_valid=%b data=%h required 0 1 %h", s_ready, m_valid, m_data, d0); end
      m_ready = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clock);
         acc = s_ready;
         @(posedge clock); #1;
      end
      if (!acc) timeouts++;
      s_valid = 1'b0;
      drain();
      checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin failures++; $display("FAIL stall_nres: got %0d required 2 (model %0d)", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL stall_model: got data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b", o.data, o.cnt, o.ovf, e.data, e.cnt, e.ovf); end
      end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL stall_timeout: got %0d timeouts required 0", timeouts); end
      timeouts = 0;
      $display("test_backpressure done");
   endtask

   task automatic test_overflow();
      res_t          e, o;
      logic [WO-1:0] pos_data;
      logic          pos_ovf;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(pack(4096, 4096, 4096, 4096), pack(2048, 2048, 2048, 2048), i == 3, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(pack(-4096, -4096, -4096, -4096), pack(2048, 2048, 2048, 2048), i == 3, 1'b0);
      send_beat(pack(7936, 7936, 7936, 7936), pack(7936, 7936, 7936, 7936), 1'b1, 1'b0);
      send_beat(pack(-8192, -8192, -8192, -8192), pack(-8192, -8192, -8192, -8192), 1'b1, 1'b0);
      drain();
`ifdef MAC_SAT_EN
      pos_data = 28'h7FFFFFF; pos_ovf = 1'b1;
`else
      pos_data = 28'h8000000; pos_ovf = 1'b0;
`endif
      checks++;
      if (obs_q.size() < 2) begin failures++; $display("FAIL ovf_first: got %0d results required >=2", obs_q.size()); end
      else begin
         checks++; if (obs_q[0].data !== pos_data || obs_q[0].ovf !== pos_ovf) begin failures++; $display("FAIL ovf_plus2048: got data=%h ovf=%b required %h %b", obs_q[0].data, obs_q[0].ovf, pos_data, pos_ovf); end
         checks++; if (obs_q[1].data !== 28'h8000000 || obs_q[1].ovf !== 1'b0) begin failures++; $display("FAIL ovf_minus2048: got data=%h ovf=%b required 8000000 0", obs_q[1].data, obs_q[1].ovf); end
      end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_nres: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL ovf_model: got data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b", o.data, o.cnt, o.ovf, e.data, e.cnt, e.ovf); end
      end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL ovf_timeout: got %0d timeouts required 0", timeouts); end
      timeouts = 0;
      $display("test_overflow done");
   endtask

   task automatic test_rounding();
      int              ta[6] = '{384, -384, 128, -128, 127, -129};
      int              te[6] = '{2, -1, 1, 0, 0, -1};
      int              a, b;
      longint          ev;
      logic [R_WO-1:0] exp_d;
      bit              got;
      r_m_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k < 6) begin
            a = ta[k]; b = 1; ev = te[k];
         end else begin
            a = int'($urandom_range(0, 16383)) - 8192;
            b = int'($urandom_range(0, 16383)) - 8192;
            ev = (longint'(a) * longint'(b) + 64'sd128) >>> 8;
         end
         exp_d = ev[R_WO-1:0];
         r_s_a = WA'(a); r_s_b = WA'(b); r_s_last = 1'b1; r_s_valid = 1'b1;
         @(posedge clock); #1;
         r_s_valid = 1'b0;
         got = 1'b0;
         for (int t = 0; t < 10 && !got; t++) begin
            @(posedge clock); #1;
            got = r_m_valid;
         end
         checks++;
         if (!got) begin failures++; $display("FAIL round_timeout case %0d: got no m_valid required 1", k); end
         else if (r_m_data !== exp_d || r_m_count !== 16'd1) begin
            failures++;
            $display("FAIL round case %0d a=%0d b=%0d: got data=%h cnt=%0d required %h 1", k, a, b, r_m_data, r_m_count, exp_d);
         end
      end
      $display("test_rounding done");
   endtask

   task automatic test_reset_mid_frame();
      res_t e, o;
      m_ready = 1'b1;
      send_beat(rand_vec(), rand_vec(), 1'b0, 1'b0);
      send_beat(rand_vec(), rand_vec(), 1'b0, 1'b0);
      rstn = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      rstn = 1'b0;
      send_beat(pack(256, 0, 0, 0), pack(256, 0, 0, 0), 1'b1, 1'b0);
      drain();
      checks++;
      if (obs_q.size() != 1) begin failures++; $display("FAIL midrst_nres: got %0d required 1", obs_q.size()); end
      else if (obs_q[0].data !== 28'h0010000 || obs_q[0].cnt !== 16'd1) begin
         failures++; $display("FAIL midrst_result: got data=%h cnt=%0d required 0010000 1", obs_q[0].data, obs_q[0].cnt);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL midrst_model: got data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b", o.data, o.cnt, o.ovf, e.data, e.cnt, e.ovf); end
      end
      m_ready = 1'b0;
      send_beat(rand_vec(), rand_vec(), 1'b1, 1'b0);
      repeat (2) begin @(posedge clock); #1; end
      checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL pend_valid: got %b required 1", m_valid); end
      rstn = 1'b1;
      @(posedge clock); #1;
      rstn = 1'b0;
      m_ready = 1'b1;
      repeat (3) begin @(posedge clock); #1; end
      checks++; if (m_valid !== 1'b0 || obs_q.size() != 0) begin failures++; $display("FAIL pend_dropped: got m_valid=%b results=%0d required 0 0", m_valid, obs_q.size()); end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL midrst_timeout: got %0d timeouts required 0", timeouts); end
      timeouts = 0;
      $display("test_reset_mid_frame done");
   endtask

   task automatic test_random();
      res_t e, o;
      int   len;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               m_ready = ($urandom_range(0, 9) < 7);
               @(posedge clock); #1;
            end
            send_beat(rand_vec(), rand_vec(), i == len - 1, 1'b1);
         end
      end
      drain();
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_nres: got %0d required %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL rand_model: got data=%h cnt=%0d ovf=%b required data=%h cnt=%0d ovf=%b", o.data, o.cnt, o.ovf, e.data, e.cnt, e.ovf); end
      end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL rand_timeout: got %0d timeouts required 0", timeouts); end
      timeouts = 0;
      $display("test_random done");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b1;
      r_s_a = '0; r_s_b = '0; r_s_valid = 1'b0; r_s_last = 1'b0; r_m_ready = 1'b1;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_rounding();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_dot_mac.md
# axis_dot_mac

Streaming fixed-point dot-product multiply-accumulate engine. Each input beat carries `LANES` signed a/b operand pairs. The block multiplies all lanes in parallel, sums them and accumulates across the beats of a frame delimited by `s_last`. Each frame produces one rounded, width-converted result on an AXI-stream style master port. It replaces the single-lane, non-pipelined MAC in the fixed-point datapath and adds full backpressure, back-to-back frames, rounding and overflow reporting.

## Interface
- `LANES`, 4: parallel multiplier lanes, ≥1.
- `INT_A`, 6: integer bits of each a operand, sign included.
- `FRAC_A`, 8: fractional bits of each a operand.
- `INT_B`, 6: integer bits of each b operand, sign included.
- `FRAC_B`, 8: fractional bits of each b operand.
- `GUARD`, 8: extra accumulator integer bits.
- `OUT_INT`, 12: result integer bits, sign included.
- `OUT_FRAC`, 16: result fractional bits.

Ports:
- `clock` in 1: sole clock; all logic on the rising edge.
- `rstn` in 1: reset; synchronous, active-high.
- `s_a` in LANES*(INT_A+FRAC_A): lane i at `[i*WA +: WA]`, signed.
- `s_b` in LANES*(INT_B+FRAC_B): lane i at `[i*WB +: WB]`, signed.
- `s_valid` in 1: input beat valid.
- `s_last` in 1: beat is the final beat of its frame.
- `s_ready` out 1: block accepts a beat this cycle.
- `m_data` out OUT_INT+OUT_FRAC: signed frame result.
- `m_valid` out 1: result valid.
- `m_last` out 1: always equal to `m_valid`, for stream compatibility.
- `m_ready` in 1: downstream accepts the result.
- `m_count` out 16: number of beats in the frame; saturates at 65535.
- `m_ovf` out 1: saturation occurred while producing this result.

## Operation
- Accept rule: a beat is accepted on a rising edge with `s_valid && s_ready`.
- Product format: PI = INT_A+INT_B, PF = FRAC_A+FRAC_B, full precision, no truncation.
- Accumulator: PI+PF+clog2(LANES)+GUARD bits, signed, two's complement.
- Pipeline stage P1: registers the LANES products of the accepted beat, plus its last flag.
- Pipeline stage P2: adds the lane sum to the accumulator.
  - On a last beat, writes the converted value of (acc + sum) to the output register and clears the accumulator to 0 in the same edge. The next frame's first beat therefore needs no bubble.
- Conversion, fraction:
  - If OUT_FRAC < PF: add 2^(PF-OUT_FRAC-1), then arithmetic shift right by PF-OUT_FRAC (round half up, toward +inf).
  - If OUT_FRAC ≥ PF: shift left by OUT_FRAC-PF.
- Conversion, integer: fit to OUT_INT+OUT_FRAC bits; behaviour is set by `MAC_SAT_EN` (see Configuration).
- Input-side FSM:
  - IDLE: no open frame, accumulator zero.
  - ACC: frame open.
  - IDLE→ACC on an accepted non-last beat.
  - ACC→IDLE on an accepted last beat.
  - IDLE→IDLE on an accepted last beat (single-beat frame).
- Beat counter: counts accepted beats per frame, saturates at 65535, is latched into `m_count` with the result, and restarts at 0 for the next frame.
- Stall: stall = `m_valid && !m_ready`. While stalled, P1, P2, accumulator, counter and FSM all hold, and `s_ready` = 0. Otherwise `s_ready` = 1.
- Output register: holds `m_data`, `m_count` and `m_ovf` stable until the handshake.

## Timing
- Reset: while `rstn`=1, `s_ready`, `m_valid`, `m_last`, `m_ovf` = 0, `m_data`, `m_count` = 0, FSM = IDLE, accumulator and pipeline flags = 0.
- Reset mid-frame: the partial accumulation and any in-flight beats are discarded. A pending result is dropped without handshake.
- Latency: a last beat accepted at edge k produces `m_valid`=1 after edge k+1, provided no stall occurs in between.
- Throughput: one beat per cycle while `m_ready`=1, including across frame boundaries.
- Simultaneous events: `m_valid && m_ready` with a new last beat arriving at P2 on the same edge loads the new result. `m_valid` stays 1 with no gap.
- `s_valid` low mid-frame: the accumulator holds and the frame stays open indefinitely.

## Configuration
- `MAC_SAT_EN` defined: integer overflow in conversion clamps to max positive (0 followed by all 1s) or max negative (1 followed by all 0s). `m_ovf`=1 for that result.
- `MAC_SAT_EN` undefined: MSBs are truncated (wrap-around). `m_ovf` is tied to 0 and no saturation logic is present.

## Test plan
- Defaults, single-beat frame, a={1.0,2.0,-1.0,0.5}, b={1.0,1.0,1.0,2.0} -> `m_data`=0x30000 (3.0), `m_count`=1, `m_last`=1, `m_valid` 2 cycles after accept.
- Two 3-beat frames back-to-back, all operands 1.0, `m_ready`=1 -> two results of 12.0 (0xC0000), `m_count`=3 each, `s_ready` never drops.
- Result pending with `m_ready` held 0 for 5 cycles -> `s_ready`=0 and `m_data` stable throughout. The next frame result is correct after release; no beat is lost or duplicated.
- OUT_INT=4, frame sum 10.0 -> with `MAC_SAT_EN`: `m_data`=0x7FFFF, `m_ovf`=1. Without it: `m_data`=0xA0000 (-6.0), `m_ovf`=0.
- OUT_FRAC=8, LANES=1, frame sum 384·2^-16 -> `m_data`=2; sum -384·2^-16 -> `m_data`=-1 (0x…FFF).
- `rstn` pulsed after 2 beats of an open frame, then a single-beat frame 1.0×1.0 -> one result only, 1.0, `m_count`=1.
